// File: rtl/tz_bitset_builder.sv
// Accumulates a stream of trailing-zeros style bit indices (BITS = "none") into a
// BITS-wide bitset, reporting distinct-bit count, duplicate and out-of-range flags per frame.
module tz_bitset_builder #(
  parameter  int unsigned BITS  = 128,
  localparam int unsigned IDX_W = $clog2(BITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_word,
  output logic [IDX_W-1:0] out_count,
  output logic             out_dup,
  output logic             out_oob
);

  typedef enum logic {ACCUM, HOLD} state_e;

  localparam logic [IDX_W-1:0] EMPTY_IDX = IDX_W'(BITS);
  localparam logic [BITS-1:0]  ONE       = BITS'(1);

  state_e           state_q, state_d;
  logic [BITS-1:0]  word_q, word_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             dup_q, dup_d;
  logic             oob_q, oob_d;

  logic [BITS-1:0]  idx_onehot;
  logic             accept;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    dup_d   = dup_q;
    oob_d   = oob_q;
    // Shifting past the top yields zero, so out-of-range indices never touch the word.
    idx_onehot = ONE << in_idx;
    accept     = in_valid && (state_q == ACCUM);

    if (accept) begin
      if (in_idx < EMPTY_IDX) begin
        if ((word_q & idx_onehot) != '0) begin
          dup_d = 1'b1;
        end else begin
          word_d  = word_q | idx_onehot;
          count_d = count_q + IDX_W'(1);
        end
      end else if (in_idx > EMPTY_IDX) begin
        oob_d = 1'b1;
      end
      if (in_last) begin
        state_d = HOLD;
      end
    end

    if ((state_q == HOLD) && out_ready) begin
      word_d  = '0;
      count_d = '0;
      dup_d   = 1'b0;
      oob_d   = 1'b0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      word_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      oob_q   <= oob_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign out_count = count_q;
  assign out_dup   = dup_q;
  assign out_oob   = oob_q;

endmodule
